// File: rtl/rate_sched_ctrl.sv
// rate_sched_ctrl: run/stop controller and divisor reconfiguration scheduler
// for the toggling clock divider. Produces a one-cycle tick at each terminal
// count and a 50%-duty toggled cout. New divisors arrive via valid/ready and
// are applied only on period boundaries, so cout never shows a runt phase.
// Optional feature macro: RATE_SCHED_ONESHOT_EN (adds the oneshot input).
module rate_sched_ctrl #(
    parameter int unsigned W         = 32,
    parameter logic [W-1:0] D_DEFAULT = W'(25000000)
) (
    input  logic         cin,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
`ifdef RATE_SCHED_ONESHOT_EN
    input  logic         oneshot,
`endif
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         tick,
    output logic         cout,
    output logic         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [W-1:0] count;
    logic [W-1:0] div_active;
    logic [W-1:0] div_pending;
    logic         pend;
    logic [W-1:0] eff_div;
    logic [W-1:0] last_count;
    logic         term;
    logic         xfer;
    logic         leave_run;
    logic         oneshot_q;

    // Effective divisor, terminal-count detect and handshake qualification.
    always_comb begin
        eff_div    = (div_active == '0) ? W'(1) : div_active;
        last_count = eff_div - W'(1);
        term       = (state == RUN) && (count >= last_count);
        xfer       = cfg_valid && !pend;
    end

`ifdef RATE_SCHED_ONESHOT_EN
    // A captured oneshot request ends the run at the first terminal count.
    always_comb begin
        leave_run = (state == RUN) && (stop || (term && oneshot_q));
    end
`else
    // Free-running until stop.
    always_comb begin
        leave_run = (state == RUN) && stop;
        oneshot_q = 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: stop wins over start; start ignored while running.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && !stop) state_next = RUN;
            RUN:  if (leave_run) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        busy      = (state == RUN);
        cfg_ready = !pend;
    end

`ifdef RATE_SCHED_ONESHOT_EN
    // Capture the oneshot request together with the start that launches RUN.
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            oneshot_q <= 1'b0;
        end else if (state == IDLE && start && !stop) begin
            oneshot_q <= oneshot;
        end
    end
`endif

    // Counter, tick/cout generation and divisor scheduling.
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            div_active  <= D_DEFAULT;
            div_pending <= '0;
            pend        <= 1'b0;
            tick        <= 1'b0;
            cout        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    tick  <= 1'b0;
                    cout  <= 1'b0;
                    if (xfer) begin
                        div_active <= cfg_div;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // Leaving RUN: a divisor offered now or already
                        // pending becomes active at once.
                        count <= '0;
                        tick  <= 1'b0;
                        cout  <= 1'b0;
                        if (xfer) begin
                            div_active <= cfg_div;
                        end else if (pend) begin
                            div_active <= div_pending;
                            pend       <= 1'b0;
                        end
                    end else if (term) begin
                        count <= '0;
                        tick  <= 1'b1;
                        cout  <= oneshot_q ? 1'b0 : !cout;
                        if (pend) begin
                            div_active <= div_pending;
                            pend       <= 1'b0;
                        end else if (xfer) begin
                            if (oneshot_q) begin
                                div_active <= cfg_div;
                            end else begin
                                // Offer on the boundary edge waits for the
                                // next boundary.
                                div_pending <= cfg_div;
                                pend        <= 1'b1;
                            end
                        end
                    end else begin
                        count <= count + W'(1);
                        tick  <= 1'b0;
                        if (xfer) begin
                            div_pending <= cfg_div;
                            pend        <= 1'b1;
                        end
                    end
                end
                default: begin
                    count <= '0;
                    tick  <= 1'b0;
                    cout  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rate_sched_ctrl.sv
// Directed testbench for rate_sched_ctrl with D_DEFAULT overridden to 4.
module tb_rate_sched_ctrl;

    localparam int unsigned W = 32;

    logic         cin;
    logic         rst_n;
    logic         start;
    logic         stop;
    logic         oneshot;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic         tick;
    logic         cout;
    logic         busy;

    int total;
    int bad;
    logic exp_cout;

    rate_sched_ctrl #(
        .W(W),
        .D_DEFAULT(32'd4)
    ) dut (
        .cin(cin),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
`ifdef RATE_SCHED_ONESHOT_EN
        .oneshot(oneshot),
`endif
        .cfg_valid(cfg_valid),
        .cfg_div(cfg_div),
        .cfg_ready(cfg_ready),
        .tick(tick),
        .cout(cout),
        .busy(busy)
    );

    initial cin = 1'b0;
    always #5 cin = ~cin;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge cin);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_tick", 32'(tick), 32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        oneshot = 1'b0;
        cfg_valid = 1'b0;
        cfg_div = '0;
        #1;
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Default divisor 4: ticks every 4 edges, cout toggling.
        pulse_start();
        exp_cout = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k % 4 == 0) exp_cout = ~exp_cout;
            chk("div4_tick", 32'(tick), (k % 4 == 0) ? 32'd1 : 32'd0);
            chk("div4_cout", 32'(cout), 32'(exp_cout));
        end

        // Offer divisor 2 just after a boundary; takes effect at next boundary.
        cfg_valid = 1'b1;
        cfg_div = 32'd2;
        step();
        cfg_valid = 1'b0;
        chk("offer_ready", 32'(cfg_ready), 32'd0);
        chk("offer_tick", 32'(tick), 32'd0);
        for (int j = 1; j <= 3; j++) begin
            step();
            chk("pend_tick", 32'(tick), (j == 3) ? 32'd1 : 32'd0);
            chk("pend_ready", 32'(cfg_ready), (j == 3) ? 32'd1 : 32'd0);
        end
        exp_cout = ~exp_cout;
        chk("pend_cout", 32'(cout), 32'(exp_cout));
        for (int j = 1; j <= 4; j++) begin
            step();
            if (j % 2 == 0) exp_cout = ~exp_cout;
            chk("div2_tick", 32'(tick), (j % 2 == 0) ? 32'd1 : 32'd0);
            chk("div2_cout", 32'(cout), 32'(exp_cout));
        end

        // Stop, then load divisor 0 in IDLE: behaves as divide-by-1.
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_cout", 32'(cout), 32'd0);
        cfg_valid = 1'b1;
        cfg_div = 32'd0;
        step();
        cfg_valid = 1'b0;
        chk("idle_load_ready", 32'(cfg_ready), 32'd1);
        pulse_start();
        exp_cout = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            step();
            exp_cout = ~exp_cout;
            chk("div1_tick", 32'(tick), 32'd1);
            chk("div1_cout", 32'(cout), 32'(exp_cout));
        end

        // Divisor 3, stop on the terminal-count edge: stop wins.
        stop = 1'b1;
        step();
        stop = 1'b0;
        cfg_valid = 1'b1;
        cfg_div = 32'd3;
        step();
        cfg_valid = 1'b0;
        pulse_start();
        for (int j = 1; j <= 2; j++) begin
            step();
            chk("div3_pre_tick", 32'(tick), 32'd0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_term_tick", 32'(tick), 32'd0);
        chk("stop_term_cout", 32'(cout), 32'd0);
        chk("stop_term_busy", 32'(busy), 32'd0);
        // Restart: count was cleared, so first tick is 3 edges later.
        pulse_start();
        for (int j = 1; j <= 3; j++) begin
            step();
            chk("restart_tick", 32'(tick), (j == 3) ? 32'd1 : 32'd0);
        end
        chk("restart_cout", 32'(cout), 32'd1);

        // Offer on a terminal-count edge, then async reset mid-cycle.
        step();
        step();
        cfg_valid = 1'b1;
        cfg_div = 32'd7;
        step();
        cfg_valid = 1'b0;
        chk("term_offer_tick", 32'(tick), 32'd1);
        chk("term_offer_ready", 32'(cfg_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_tick", 32'(tick), 32'd0);
        chk("async_cout", 32'(cout), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_ready", 32'(cfg_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        pulse_start();
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("post_rst_tick", 32'(tick), (k % 4 == 0) ? 32'd1 : 32'd0);
        end

`ifdef RATE_SCHED_ONESHOT_EN
        stop = 1'b1;
        step();
        stop = 1'b0;
        cfg_valid = 1'b1;
        cfg_div = 32'd5;
        step();
        cfg_valid = 1'b0;
        oneshot = 1'b1;
        pulse_start();
        oneshot = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("oneshot_tick", 32'(tick), (k == 5) ? 32'd1 : 32'd0);
            chk("oneshot_busy", 32'(busy), (k < 5) ? 32'd1 : 32'd0);
            chk("oneshot_cout", 32'(cout), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
